// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and widths for the MIPS multicycle memory interface
package mips_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_DONE = 2'd2
  } memif_state_t;

  localparam int WORD_W = 32;

endpackage

// File: rtl/mips_mem_if_if.sv
// rtl/mips_mem_if_if.sv - req/ack memory bus between mips_mem_if (master) and the memory (slave)
interface mips_mem_if_if
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W
);
  logic             req;
  logic             we;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic             ack;
  logic [WIDTH-1:0] rdata;
  logic             err;

  modport master (
    output req, we, addr, wdata, err,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata, err,
    output ack, rdata
  );
endinterface

// File: rtl/mips_mem_wdog.sv
// rtl/mips_mem_wdog.sv - REQ-phase watchdog: flags expiry on the TIMEOUT-th enabled cycle
module mips_mem_wdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Combinational so the FSM leaves REQ on the edge closing the TIMEOUT-th cycle.
  assign expired = en && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mips_mem_if.sv
// rtl/mips_mem_if.sv - multicycle memory interface: address select, req/ack handshake, mdr
// Optional REQ timeout with sticky bus_err enabled by defining MIPS_MEM_TIMEOUT_EN.
module mips_mem_if
  import mips_pkg::*;
#(
  parameter int WIDTH   = WORD_W,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memread,
  input  logic             memwrite,
  input  logic             iord,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] aluout,
  input  logic [WIDTH-1:0] wdata,
  output logic             memready,
  output logic [WIDTH-1:0] mdr,
  mips_mem_if_if.master    bus
);
  localparam logic [1:0] ST_IDLE = MEM_IDLE;
  localparam logic [1:0] ST_REQ  = MEM_REQ;
  localparam logic [1:0] ST_DONE = MEM_DONE;

  logic [1:0]       state;
  logic             req_q;
  logic             we_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] sel;
  logic             accept;
  logic             expired;
  logic             err_set;

  assign sel    = iord ? aluout : pc;
  assign accept = (state == ST_IDLE) && (memread || memwrite);

`ifdef MIPS_MEM_TIMEOUT_EN
  logic err_q;

  mips_mem_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept),
    .en      (state == ST_REQ),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign expired        = 1'b0;
  assign bus.err        = 1'b0;
`endif

  assign err_set = (state == ST_REQ) && !bus.ack && expired;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      memready <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mdr      <= '0;
    end else begin
      memready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            // Word-align and freeze the address; write wins when both strobes are high.
            addr_q  <= sel & {{(WIDTH-2){1'b1}}, 2'b00};
            we_q    <= memwrite;
            wdata_q <= wdata;
            req_q   <= 1'b1;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.ack) begin
            if (!we_q) begin
              mdr <= bus.rdata;
            end
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            memready <= 1'b1;
            state    <= ST_DONE;
          end else if (expired) begin
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            memready <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req   = req_q;
  assign bus.we    = we_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
endmodule

// File: tb/tb_mips_mem_if.sv
// tb/tb_mips_mem_if.sv - directed self-checking bench for mips_mem_if
module tb_mips_mem_if;
  logic        clk;
  logic        rst_n;
  logic        memread;
  logic        memwrite;
  logic        iord;
  logic [31:0] pc;
  logic [31:0] aluout;
  logic [31:0] wdata;
  logic        memready;
  logic [31:0] mdr;

  int checks   = 0;
  int failures = 0;

  mips_mem_if_if #(.WIDTH(32)) bus ();

  mips_mem_if #(.WIDTH(32), .TIMEOUT(16)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .memread  (memread),
    .memwrite (memwrite),
    .iord     (iord),
    .pc       (pc),
    .aluout   (aluout),
    .wdata    (wdata),
    .memready (memready),
    .mdr      (mdr),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobes must already be set; the next edge is the accept edge. waits<0 means never ack.
  task automatic access(input int waits, input bit perturb, input int limit,
                        output int rdy, output int we_cyc, output int req_cyc,
                        output logic [31:0] addr_seen, output logic [31:0] wd_seen,
                        output bit addr_stable);
    rdy = -1; we_cyc = 0; req_cyc = 0; addr_stable = 1'b1;
    tick();
    addr_seen = bus.addr;
    wd_seen   = bus.wdata;
    for (int k = 1; k <= limit; k++) begin
      if (memready) begin
        rdy      = k;
        memread  = 1'b0;
        memwrite = 1'b0;
        bus.ack  = 1'b0;
        break;
      end
      if (bus.req) req_cyc++;
      if (bus.we) we_cyc++;
      if (bus.addr !== addr_seen) addr_stable = 1'b0;
      bus.ack = (waits >= 0) && (k == waits + 1);
      if (perturb && k == 2) begin
        pc     = 32'h0000_0F00;
        aluout = 32'h0000_0A00;
      end
      tick();
    end
    if (rdy < 0) begin
      memread  = 1'b0;
      memwrite = 1'b0;
      bus.ack  = 1'b0;
    end
  endtask

  initial begin
    int          rdy, we_cyc, req_cyc;
    logic [31:0] a_seen, w_seen;
    bit          stable;

    rst_n = 1'b0; memread = 1'b0; memwrite = 1'b0; iord = 1'b0;
    pc = '0; aluout = '0; wdata = '0; bus.ack = 1'b0; bus.rdata = '0;
    tick(); tick();
    chk("rst_memready", {31'd0, memready}, 32'd0);
    chk("rst_req", {31'd0, bus.req}, 32'd0);
    chk("rst_we", {31'd0, bus.we}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_addr", bus.addr, 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);
    chk("rst_mdr", mdr, 32'd0);
    rst_n = 1'b1;
    tick();

    // T2 instruction fetch, ack in first REQ cycle
    iord = 1'b0; pc = 32'h0000_0004; memread = 1'b1; bus.rdata = 32'h8C01_0000;
    access(0, 1'b0, 40, rdy, we_cyc, req_cyc, a_seen, w_seen, stable);
    chk("t2_addr", a_seen, 32'h0000_0004);
    chk("t2_we_cycles", we_cyc, 0);
    chk("t2_req_cycles", req_cyc, 1);
    chk("t2_ready_cycle", rdy, 2);
    chk("t2_mdr", mdr, 32'h8C01_0000);
    chk("t2_req_low_done", {31'd0, bus.req}, 32'd0);
    tick();
    chk("t2_ready_pulse", {31'd0, memready}, 32'd0);

    // ack while idle must be ignored
    bus.ack = 1'b1; bus.rdata = 32'h1111_2222;
    tick();
    chk("idle_ack_ready", {31'd0, memready}, 32'd0);
    chk("idle_ack_req", {31'd0, bus.req}, 32'd0);
    chk("idle_ack_mdr", mdr, 32'h8C01_0000);
    bus.ack = 1'b0;

    // T3 store, unaligned ALUOut, 3 wait states
    iord = 1'b1; aluout = 32'h0000_0013; wdata = 32'hDEAD_BEEF; memwrite = 1'b1;
    bus.rdata = 32'h5555_5555;
    access(3, 1'b0, 40, rdy, we_cyc, req_cyc, a_seen, w_seen, stable);
    chk("t3_addr", a_seen, 32'h0000_0010);
    chk("t3_wdata", w_seen, 32'hDEAD_BEEF);
    chk("t3_we_cycles", we_cyc, 4);
    chk("t3_ready_cycle", rdy, 5);
    chk("t3_mdr", mdr, 32'h8C01_0000);
    chk("t3_we_low_done", {31'd0, bus.we}, 32'd0);
    tick();

    // T4 both strobes: write wins
    aluout = 32'h0000_0100; wdata = 32'h1234_5678; memread = 1'b1; memwrite = 1'b1;
    bus.rdata = 32'hFFFF_FFFF;
    access(0, 1'b0, 40, rdy, we_cyc, req_cyc, a_seen, w_seen, stable);
    chk("t4_we_cycles", we_cyc, 1);
    chk("t4_addr", a_seen, 32'h0000_0100);
    chk("t4_mdr", mdr, 32'h8C01_0000);
    tick();

    // T5 pc/aluout change mid-REQ on a read
    iord = 1'b1; aluout = 32'h0000_0022; pc = 32'h0000_0040; memread = 1'b1;
    bus.rdata = 32'hA5A5_5A5A;
    access(2, 1'b1, 40, rdy, we_cyc, req_cyc, a_seen, w_seen, stable);
    chk("t5_addr", a_seen, 32'h0000_0020);
    chk("t5_addr_stable", {31'd0, stable}, 32'd1);
    chk("t5_ready_cycle", rdy, 4);
    chk("t5_mdr", mdr, 32'hA5A5_5A5A);
    tick();

`ifndef MIPS_MEM_TIMEOUT_EN
    // Without the timeout a long wait completes normally and bus_err stays 0
    iord = 1'b0; pc = 32'h0000_0008; memread = 1'b1; bus.rdata = 32'h0BAD_F00D;
    access(20, 1'b0, 60, rdy, we_cyc, req_cyc, a_seen, w_seen, stable);
    chk("long_req_cycles", req_cyc, 21);
    chk("long_ready_cycle", rdy, 22);
    chk("long_mdr", mdr, 32'h0BAD_F00D);
    chk("long_err", {31'd0, bus.err}, 32'd0);
    tick();
`endif

    // T1 reset mid-REQ
    iord = 1'b0; pc = 32'h0000_0030; memread = 1'b1;
    tick(); tick(); tick();
    chk("t1_req_before", {31'd0, bus.req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_req_async", {31'd0, bus.req}, 32'd0);
    chk("t1_addr_async", bus.addr, 32'd0);
    chk("t1_mdr_async", mdr, 32'd0);
    memread = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("t1_idle_req", {31'd0, bus.req}, 32'd0);
    chk("t1_idle_ready", {31'd0, memready}, 32'd0);
    pc = 32'h0000_0044; memread = 1'b1; bus.rdata = 32'hCAFE_0001;
    access(1, 1'b0, 40, rdy, we_cyc, req_cyc, a_seen, w_seen, stable);
    chk("t1_post_addr", a_seen, 32'h0000_0044);
    chk("t1_post_ready", rdy, 3);
    chk("t1_post_mdr", mdr, 32'hCAFE_0001);
    tick();

`ifdef MIPS_MEM_TIMEOUT_EN
    // T6 never ack: 16 REQ cycles then timeout
    iord = 1'b0; pc = 32'h0000_0050; memread = 1'b1; bus.rdata = 32'h7777_7777;
    access(-1, 1'b0, 40, rdy, we_cyc, req_cyc, a_seen, w_seen, stable);
    chk("t6_req_cycles", req_cyc, 16);
    chk("t6_ready_cycle", rdy, 17);
    chk("t6_err", {31'd0, bus.err}, 32'd1);
    chk("t6_mdr", mdr, 32'hCAFE_0001);
    tick();
    pc = 32'h0000_0060; memread = 1'b1; bus.rdata = 32'h0000_0099;
    access(0, 1'b0, 40, rdy, we_cyc, req_cyc, a_seen, w_seen, stable);
    chk("t6_after_mdr", mdr, 32'h0000_0099);
    chk("t6_err_sticky", {31'd0, bus.err}, 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_err_reset", {31'd0, bus.err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
